// File: rtl/spy_fifo_pkg.sv
// spy_fifo_pkg: shared types and helpers for the spy capture FIFO
package spy_fifo_pkg;
    typedef enum logic {FIFO_MODE_REG, FIFO_MODE_FWFT} fifo_mode_e;
    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction
    // Explicit wrap so non-power-of-2 depths index correctly
    function automatic int ptr_inc(input int ptr, input int depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction
endpackage

// File: rtl/spy_fifo_mem.sv
// spy_fifo_mem: 1W1R storage array with asynchronous read, no reset
module spy_fifo_mem #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 32,
    parameter int PTR_W      = 5
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [PTR_W-1:0]      waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [PTR_W-1:0]      raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;
    assign rdata = mem[raddr];
endmodule

// File: rtl/spy_sync_fifo.sv
// spy_sync_fifo: single-clock FIFO with FWFT/registered read, thresholds, flush and sticky errors
module spy_sync_fifo
    import spy_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int FIFO_DEPTH = 32,
    parameter int FWFT_MODE  = 1,
    parameter int AF_THRESH  = 28,
    parameter int AE_THRESH  = 4,
    localparam int PTR_W = ptr_w(FIFO_DEPTH),
    localparam int CNT_W = cnt_w(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  flush_i,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] pop_data_o,
    output logic                  pop_valid_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic                  almost_full_o,
    output logic                  almost_empty_o,
    output logic [CNT_W-1:0]      count_o,
    output logic                  overflow_o,
    output logic                  underflow_o,
    input  logic                  clr_err_i
);
    localparam fifo_mode_e MODE = (FWFT_MODE != 0) ? FIFO_MODE_FWFT : FIFO_MODE_REG;
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [CNT_W-1:0]      count_q;
    logic [DATA_WIDTH-1:0] rd_data, data_q;
    logic                  valid_q, ovf_q, unf_q;
    logic                  pop_acc, push_acc, ovf_set, unf_set;
    always_comb begin
        pop_acc  = pop_i & ~empty_o;
        push_acc = push_i & (~full_o | pop_acc);
        ovf_set  = ~flush_i & push_i & ~push_acc;
        unf_set  = ~flush_i & pop_i & ~pop_acc;
    end
    spy_fifo_mem #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH), .PTR_W(PTR_W)) u_mem (
        .clk   (clk),
        .we    (push_acc & ~flush_i),
        .waddr (wr_ptr),
        .wdata (push_data_i),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            ovf_q <= ovf_set | (ovf_q & ~clr_err_i);
            unf_q <= unf_set | (unf_q & ~clr_err_i);
            if (flush_i) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                count_q <= '0;
                valid_q <= 1'b0;
            end else begin
                if (push_acc) wr_ptr <= PTR_W'(ptr_inc(int'(wr_ptr), FIFO_DEPTH));
                if (pop_acc) rd_ptr <= PTR_W'(ptr_inc(int'(rd_ptr), FIFO_DEPTH));
                if (pop_acc) data_q <= rd_data;
                count_q <= count_q + CNT_W'(push_acc) - CNT_W'(pop_acc);
                valid_q <= pop_acc;
            end
        end
    assign empty_o        = count_q == '0;
    assign full_o         = count_q == CNT_W'(FIFO_DEPTH);
    assign almost_full_o  = count_q >= CNT_W'(AF_THRESH);
    assign almost_empty_o = count_q <= CNT_W'(AE_THRESH);
    assign count_o        = count_q;
    assign overflow_o     = ovf_q;
    assign underflow_o    = unf_q;
    assign pop_data_o     = (MODE == FIFO_MODE_FWFT) ? rd_data : data_q;
    assign pop_valid_o    = (MODE == FIFO_MODE_FWFT) ? ~empty_o : valid_q;
endmodule
